stage_mem: RTL

//  MIPS MEM pipeline stage. Sits between the EX/MEM latch and the MEM/WB latch. Performs

---
 rtl/stage_mem.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/stage_mem.sv
// MIPS MEM stage: drives a request/ack data bus for loads and stores, formats
// load data (byte/half/word, sign/zero extend), passes ALU results through for
// non-memory ops, and stalls the front of the pipe while an access is in flight.
module stage_mem #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter bit BIG_ENDIAN     = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  ex_memory_operation,
    input  logic [31:0] ex_memory_address,
    input  logic [31:0] ex_memory_store_data,
    input  logic        ex_register_write_enable,
    input  logic [4:0]  ex_register_write_address,
    input  logic [31:0] ex_register_write_data,
    output logic        mem_register_write_enable,
    output logic [4:0]  mem_register_write_address,
    output logic [31:0] mem_register_write_data,
    output logic        stall_request,
    output logic        bus_request,
    output logic        bus_write,
    output logic [31:0] bus_address,
    output logic [3:0]  bus_byte_select,
    output logic [31:0] bus_write_data,
    input  logic        bus_ack,
    input  logic [31:0] bus_read_data,
    output logic        address_error,
    output logic        bus_error
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state, state_next;
    logic        is_load, is_store, is_mem, misaligned, start;
    logic [1:0]  byte_lane;
    logic        half_lane;
    logic [3:0]  sel_next;
    logic [31:0] wdata_next;
    logic [CW-1:0] count;
    logic [31:0] read_word;
    logic        aborted;
    logic [3:0]  op_q;
    logic [1:0]  addr_lo_q;
    logic [1:0]  rd_byte_lane;
    logic        rd_half_lane;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_value;

    // Lane 3 is bits 31:24; big-endian maps offset 0 onto the top lane.
    assign byte_lane    = BIG_ENDIAN ? ~ex_memory_address[1:0] : ex_memory_address[1:0];
    assign half_lane    = BIG_ENDIAN ? ~ex_memory_address[1] : ex_memory_address[1];
    assign rd_byte_lane = BIG_ENDIAN ? ~addr_lo_q : addr_lo_q;
    assign rd_half_lane = BIG_ENDIAN ? ~addr_lo_q[1] : addr_lo_q[1];

    // Decode the incoming op: class, alignment, lane enables and replicated store data.
    always_comb begin
        is_load    = (ex_memory_operation >= OP_LB) && (ex_memory_operation <= OP_LW);
        is_store   = (ex_memory_operation >= OP_SB) && (ex_memory_operation <= OP_SW);
        misaligned = 1'b0;
        sel_next   = 4'b1111;
        wdata_next = ex_memory_store_data;
        case (ex_memory_operation)
            OP_LB, OP_LBU, OP_SB: begin
                sel_next   = 4'b0001 << byte_lane;
                wdata_next = {4{ex_memory_store_data[7:0]}};
            end
            OP_LH, OP_LHU, OP_SH: begin
                misaligned = ex_memory_address[0];
                sel_next   = half_lane ? 4'b1100 : 4'b0011;
                wdata_next = {2{ex_memory_store_data[15:0]}};
            end
            OP_LW, OP_SW: misaligned = |ex_memory_address[1:0];
            default: ;
        endcase
        is_mem = is_load || is_store;
    end

    assign start = (state == IDLE) && is_mem && !misaligned;

    // Extract and extend the captured word for the latched load type.
    always_comb begin
        case (rd_byte_lane)
            2'd0:    rd_byte = read_word[7:0];
            2'd1:    rd_byte = read_word[15:8];
            2'd2:    rd_byte = read_word[23:16];
            default: rd_byte = read_word[31:24];
        endcase
        rd_half = rd_half_lane ? read_word[31:16] : read_word[15:0];
        case (op_q)
            OP_LB:   load_value = {{24{rd_byte[7]}}, rd_byte};
            OP_LBU:  load_value = {24'd0, rd_byte};
            OP_LH:   load_value = {{16{rd_half[15]}}, rd_half};
            OP_LHU:  load_value = {16'd0, rd_half};
            default: load_value = read_word;
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next state and combinational pipeline outputs.
    always_comb begin
        state_next                 = state;
        stall_request              = 1'b0;
        address_error              = 1'b0;
        mem_register_write_enable  = 1'b0;
        mem_register_write_address = ex_register_write_address;
        mem_register_write_data    = ex_register_write_data;
        case (state)
            IDLE: begin
                if (is_mem && misaligned) begin
                    address_error = 1'b1;
                end else if (is_mem) begin
                    stall_request = 1'b1;
                    state_next    = ACCESS;
                end else begin
                    mem_register_write_enable = ex_register_write_enable;
                end
            end
            ACCESS: begin
                stall_request = 1'b1;
                if (bus_ack || (count == CW'(TIMEOUT_CYCLES - 1))) state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
                if (op_q >= OP_LB && op_q <= OP_LW) begin
                    mem_register_write_enable = ex_register_write_enable && !aborted;
                    mem_register_write_data   = load_value;
                end
            end
            default: state_next = IDLE;
        endcase
        if (!reset) begin
            state_next                 = IDLE;
            stall_request              = 1'b0;
            address_error              = 1'b0;
            mem_register_write_enable  = 1'b0;
            mem_register_write_address = 5'd0;
            mem_register_write_data    = 32'd0;
        end
    end

    // Bus registers, timeout counter, read capture and abort tracking.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus_request     <= 1'b0;
            bus_write       <= 1'b0;
            bus_address     <= 32'd0;
            bus_byte_select <= 4'd0;
            bus_write_data  <= 32'd0;
            bus_error       <= 1'b0;
            count           <= '0;
            read_word       <= 32'd0;
            aborted         <= 1'b0;
            op_q            <= 4'd0;
            addr_lo_q       <= 2'd0;
        end else begin
            bus_error <= 1'b0;
            if (start) begin
                bus_request     <= 1'b1;
                bus_write       <= is_store;
                bus_address     <= {ex_memory_address[31:2], 2'b00};
                bus_byte_select <= sel_next;
                bus_write_data  <= wdata_next;
                count           <= '0;
                aborted         <= 1'b0;
                op_q            <= ex_memory_operation;
                addr_lo_q       <= ex_memory_address[1:0];
            end else if (state == ACCESS) begin
                if (bus_ack) begin
                    bus_request <= 1'b0;
                    read_word   <= bus_read_data;
                end else if (count == CW'(TIMEOUT_CYCLES - 1)) begin
                    bus_request <= 1'b0;
                    bus_error   <= 1'b1;
                    aborted     <= 1'b1;
                end else begin
                    count <= count + CW'(1);
                end
            end
        end
    end
endmodule
